// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: four-way round-robin arbiter for text-buffer write ports.
// A requester may lock the port for a burst of writes. Each accepted write is
// registered onto the buffer port one cycle after its ack.
// Writes to addresses above MAX_ADDR are acked and then dropped, and the
// sticky addr_err flag is set.
//   clk, rst      : clock, synchronous active-high reset
//   req[3:0]      : per-requester write request, held until acked
//   req_addr[47:0]: requester i address in bits [12i+11:12i]
//   req_data[63:0]: requester i data in bits [16i+15:16i]
//   req_lock[3:0] : requester i keeps the port after the current write
//   ack[3:0]      : combinational one-hot accept
//   vga_addr/vga_data/vga_we : registered buffer write port
//   busy          : port locked to one requester
//   addr_err      : sticky out-of-range write flag
//   wr_count      : saturating count of legal writes issued
module vga_write_arbiter #(
    parameter logic [11:0] MAX_ADDR = 12'd2399
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [47:0] req_addr,
    input  logic [63:0] req_data,
    input  logic [3:0]  req_lock,
    output logic [3:0]  ack,
    output logic [11:0] vga_addr,
    output logic [15:0] vga_data,
    output logic        vga_we,
    output logic        busy,
    output logic        addr_err,
    output logic [15:0] wr_count
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 16;
    localparam int unsigned CW    = 16;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t         state_q, state_d;
    logic [1:0]     rr_q, rr_d;
    logic [1:0]     owner_q, owner_d;
    logic           grant_vld;
    logic [1:0]     grant_idx;
    logic [1:0]     idx;
    logic [AW-1:0]  addr_arr [N_REQ];
    logic [DW-1:0]  data_arr [N_REQ];
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_data;
    logic           addr_legal;

    // Unpack the flat requester buses
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            addr_arr[k] = req_addr[k*AW +: AW];
            data_arr[k] = req_data[k*DW +: DW];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            rr_q    <= 2'd0;
            owner_q <= 2'd0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    // Grant selection and next-state logic
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        idx       = 2'd0;
        ack       = 4'b0000;
        case (state_q)
            ARB: begin
                // First requesting port at or after rr_ptr, wrapping 3 -> 0
                for (int k = 0; k < N_REQ; k++) begin
                    idx = rr_q + 2'(k);
                    if (!grant_vld && req[idx]) begin
                        grant_vld = 1'b1;
                        grant_idx = idx;
                    end
                end
                if (grant_vld) begin
                    if (req_lock[grant_idx]) begin
                        state_d = LOCKED;
                        owner_d = grant_idx;
                    end else begin
                        rr_d = grant_idx + 2'd1;
                    end
                end
            end
            LOCKED: begin
                if (req[owner_q]) begin
                    grant_vld = 1'b1;
                    grant_idx = owner_q;
                    if (!req_lock[owner_q]) begin
                        state_d = ARB;
                        rr_d    = owner_q + 2'd1;
                    end
                end else begin
                    // Owner walked away: release without a write
                    state_d = ARB;
                    rr_d    = owner_q + 2'd1;
                end
            end
            default: state_d = ARB;
        endcase
        if (rst) begin
            grant_vld = 1'b0;
        end
        if (grant_vld) begin
            ack = 4'b0001 << grant_idx;
        end
    end

    assign sel_addr   = addr_arr[grant_idx];
    assign sel_data   = data_arr[grant_idx];
    assign addr_legal = (sel_addr <= MAX_ADDR);
    assign busy       = (state_q == LOCKED);

    // Registered buffer write port, error flag and write counter
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_addr <= '0;
            vga_data <= '0;
            vga_we   <= 1'b0;
            addr_err <= 1'b0;
            wr_count <= '0;
        end else begin
            vga_we <= grant_vld && addr_legal;
            if (grant_vld && addr_legal) begin
                vga_addr <= sel_addr;
                vga_data <= sel_data;
                if (wr_count != {CW{1'b1}}) begin
                    wr_count <= wr_count + CW'(1);
                end
            end
            if (grant_vld && !addr_legal) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter. Inputs change 1 ns after a rising
// edge. The combinational ack is checked 1 ns later. Registered outputs are
// checked 1 ns after the following edge.
module tb_vga_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [47:0] req_addr;
    logic [63:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  ack;
    logic [11:0] vga_addr;
    logic [15:0] vga_data;
    logic        vga_we;
    logic        busy;
    logic        addr_err;
    logic [15:0] wr_count;

    int total = 0;
    int bad   = 0;

    vga_write_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_lock (req_lock),
        .ack      (ack),
        .vga_addr (vga_addr),
        .vga_data (vga_data),
        .vga_we   (vga_we),
        .busy     (busy),
        .addr_err (addr_err),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic [11:0] a, input logic [15:0] d);
        req_addr[i*12 +: 12] = a;
        req_data[i*16 +: 16] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        req_lock = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        req_lock = 4'b1111;
        req_addr = '0;
        req_data = '0;
        tick();
        tick();
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        total++; if (vga_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", vga_we); end
        total++; if (vga_addr !== 12'd0 || vga_data !== 16'd0) begin bad++; $display("FAIL reset_port got=%0d/%h exp=0/0", vga_addr, vga_data); end
        total++; if (busy !== 1'b0 || addr_err !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", busy, addr_err); end
        total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", wr_count); end
        req = 4'b0000;
        req_lock = 4'b0000;
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) set_port(i, 12'(10 + i), 16'(16'hA000 + i));
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            total++;
            if (ack !== 4'(4'b0001 << (c % 4))) begin
                bad++; $display("FAIL rr_ack cycle=%0d got=%b exp_idx=%0d", c, ack, c % 4);
            end
            tick();
            total++;
            if (vga_we !== 1'b1 || vga_addr !== 12'(10 + c % 4) || vga_data !== 16'(16'hA000 + c % 4)) begin
                bad++; $display("FAIL rr_write cycle=%0d got we=%b addr=%0d data=%h exp addr=%0d", c, vga_we, vga_addr, vga_data, 10 + c % 4);
            end
        end
        req = 4'b0000;
        #1;
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL rr_idle_ack got=%b exp=0000", ack); end
        tick();
        total++; if (vga_we !== 1'b0) begin bad++; $display("FAIL rr_idle_we got=%b exp=0", vga_we); end
        total++; if (wr_count !== 16'd8) begin bad++; $display("FAIL rr_count got=%0d exp=8", wr_count); end
    endtask

    task automatic test_lock_burst();
        do_reset();
        set_port(0, 12'd40, 16'h0040);
        set_port(2, 12'd100, 16'h0100);
        req = 4'b0100;
        req_lock = 4'b0100;
        #1;
        total++; if (ack !== 4'b0100) begin bad++; $display("FAIL lock_ack1 got=%b exp=0100", ack); end
        tick();
        total++; if (busy !== 1'b1 || vga_addr !== 12'd100) begin bad++; $display("FAIL lock_w1 got busy=%b addr=%0d exp 1/100", busy, vga_addr); end
        req = 4'b0101;
        set_port(2, 12'd101, 16'h0101);
        #1;
        total++; if (ack !== 4'b0100) begin bad++; $display("FAIL lock_ack2 got=%b exp=0100", ack); end
        tick();
        total++; if (busy !== 1'b1 || vga_addr !== 12'd101 || vga_we !== 1'b1) begin bad++; $display("FAIL lock_w2 got busy=%b addr=%0d we=%b exp 1/101/1", busy, vga_addr, vga_we); end
        set_port(2, 12'd102, 16'h0102);
        req_lock = 4'b0000;
        #1;
        total++; if (ack !== 4'b0100) begin bad++; $display("FAIL lock_ack3 got=%b exp=0100", ack); end
        tick();
        total++; if (busy !== 1'b0 || vga_addr !== 12'd102) begin bad++; $display("FAIL lock_w3 got busy=%b addr=%0d exp 0/102", busy, vga_addr); end
        req = 4'b0001;
        #1;
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL lock_release_ack got=%b exp=0001", ack); end
        tick();
        total++; if (vga_we !== 1'b1 || vga_addr !== 12'd40) begin bad++; $display("FAIL lock_release_w got we=%b addr=%0d exp 1/40", vga_we, vga_addr); end
        req = 4'b0000;
    endtask

    task automatic test_addr_err();
        do_reset();
        set_port(1, 12'd2399, 16'hBEEF);
        req = 4'b0010;
        #1;
        total++; if (ack !== 4'b0010) begin bad++; $display("FAIL edge_ack got=%b exp=0010", ack); end
        tick();
        total++; if (vga_we !== 1'b1 || vga_addr !== 12'd2399 || addr_err !== 1'b0 || wr_count !== 16'd1) begin
            bad++; $display("FAIL edge_write got we=%b addr=%0d err=%b cnt=%0d exp 1/2399/0/1", vga_we, vga_addr, addr_err, wr_count);
        end
        set_port(1, 12'd2400, 16'hDEAD);
        #1;
        total++; if (ack !== 4'b0010) begin bad++; $display("FAIL bad_addr_ack got=%b exp=0010", ack); end
        tick();
        total++; if (vga_we !== 1'b0 || addr_err !== 1'b1 || wr_count !== 16'd1 || vga_addr !== 12'd2399) begin
            bad++; $display("FAIL bad_addr_write got we=%b err=%b cnt=%0d addr=%0d exp 0/1/1/2399", vga_we, addr_err, wr_count, vga_addr);
        end
        req = 4'b0000;
        tick();
        total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL addr_err_sticky got=%b exp=1", addr_err); end
    endtask

    task automatic test_owner_drop();
        do_reset();
        set_port(0, 12'd7, 16'h0007);
        set_port(3, 12'd9, 16'h0009);
        req = 4'b1000;
        req_lock = 4'b1000;
        #1;
        total++; if (ack !== 4'b1000) begin bad++; $display("FAIL drop_ack1 got=%b exp=1000", ack); end
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy got=%b exp=1", busy); end
        req = 4'b0001;
        req_lock = 4'b0000;
        #1;
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL drop_stall got=%b exp=0000", ack); end
        tick();
        total++; if (busy !== 1'b0 || vga_we !== 1'b0) begin bad++; $display("FAIL drop_release got busy=%b we=%b exp 0/0", busy, vga_we); end
        req = 4'b0011;
        #1;
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL drop_wrap_ack got=%b exp=0001", ack); end
        tick();
        total++; if (vga_we !== 1'b1 || vga_addr !== 12'd7) begin bad++; $display("FAIL drop_wrap_w got we=%b addr=%0d exp 1/7", vga_we, vga_addr); end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_port(0, 12'd5, 16'h0055);
        set_port(1, 12'd6, 16'h0066);
        req = 4'b0001;
        req_lock = 4'b0001;
        #1;
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL mid_ack got=%b exp=0001", ack); end
        tick();
        rst = 1'b1;
        #1;
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL mid_rst_ack got=%b exp=0000", ack); end
        tick();
        total++; if (vga_we !== 1'b0 || busy !== 1'b0 || vga_addr !== 12'd0 || vga_data !== 16'd0 || wr_count !== 16'd0) begin
            bad++; $display("FAIL mid_rst_state got we=%b busy=%b addr=%0d data=%h cnt=%0d exp all 0", vga_we, busy, vga_addr, vga_data, wr_count);
        end
        rst = 1'b0;
        req = 4'b0010;
        req_lock = 4'b0000;
        #1;
        total++; if (ack !== 4'b0010) begin bad++; $display("FAIL mid_unlocked got=%b exp=0010", ack); end
        tick();
        req = 4'b0000;
    endtask

    task automatic test_saturate();
        do_reset();
        set_port(0, 12'd3, 16'h0003);
        req = 4'b0001;
        repeat (65534) tick();
        total++; if (wr_count !== 16'hFFFE) begin bad++; $display("FAIL sat_preload got=%h exp=fffe", wr_count); end
        tick();
        total++; if (wr_count !== 16'hFFFF) begin bad++; $display("FAIL sat_max got=%h exp=ffff", wr_count); end
        tick();
        total++; if (wr_count !== 16'hFFFF || vga_we !== 1'b1) begin bad++; $display("FAIL sat_hold got=%h we=%b exp ffff/1", wr_count, vga_we); end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        req_lock = 4'b0000;
        req_addr = '0;
        req_data = '0;
        test_reset();
        test_round_robin();
        test_lock_burst();
        test_addr_err();
        test_owner_drop();
        test_reset_mid_burst();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_write_arbiter.md
VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 Parameter MAX_ADDR, default 12'd2399, is the highest legal text-buffer cell address (80 columns x 30 rows).
REQ-002 Port clk, input, 1: clock; all state changes on the rising edge.
REQ-003 Port rst, input, 1: reset, synchronous, active-high.
REQ-004 Port req, input, 4: per-requester write request; req[i] held high until ack[i].
REQ-005 Port req_addr, input, 48: requester i cell address in bits [12i+11:12i].
REQ-006 Port req_data, input, 64: requester i character/attribute word in bits [16i+15:16i].
REQ-007 Port req_lock, input, 4: requester i asks to keep the port after the current write (burst).
REQ-008 Port ack, output, 4: one-hot, combinational; ack[i]=1 means requester i's write is accepted this cycle.
REQ-009 Port vga_addr, output, 12: registered text-buffer write address.
REQ-010 Port vga_data, output, 16: registered text-buffer write data.
REQ-011 Port vga_we, output, 1: registered write enable, one cycle per accepted legal write.
REQ-012 Port busy, output, 1: high while in state LOCKED.
REQ-013 Port addr_err, output, 1: sticky flag; set by any accepted write with address > MAX_ADDR.
REQ-014 Port wr_count, output, 16: count of legal writes issued; saturates at 16'hFFFF.

Function
REQ-015 The block SHALL have two states: ARB and LOCKED.
REQ-016 In ARB, the block SHALL grant the lowest-numbered requester with req high, searching upward from rr_ptr and wrapping from 3 to 0.
REQ-017 At most one ack bit SHALL be high in any cycle, and no ack SHALL be raised when req is 4'b0000.
REQ-018 On ack[i], the block SHALL set rr_ptr to (i+1) mod 4, unless the next state is LOCKED.
REQ-019 On ack[i] with req_lock[i]=1, the next state SHALL be LOCKED with owner=i; otherwise the next state SHALL be ARB.
REQ-020 In LOCKED, only the owner SHALL be eligible; ack[owner] SHALL equal req[owner] and all other requesters SHALL stall.
REQ-021 In LOCKED, an ack with req_lock[owner]=0 SHALL return the block to ARB and set rr_ptr to (owner+1) mod 4.
REQ-022 In LOCKED, if req[owner]=0, the block SHALL return to ARB in the next cycle with no write issued and rr_ptr set to (owner+1) mod 4.
REQ-023 Latency: on an ack in cycle N, the block SHALL drive vga_addr, vga_data and vga_we=1 in cycle N+1.
REQ-024 An accepted write with address > MAX_ADDR SHALL still be acked, but in cycle N+1 vga_we SHALL be 0 and addr_err SHALL be set.
REQ-025 vga_we SHALL be 0 in every cycle that does not follow an ack; vga_addr and vga_data SHALL hold their last values.
REQ-026 wr_count SHALL increment by 1 in the cycle vga_we is asserted and SHALL hold at 16'hFFFF.
REQ-027 Address compares SHALL be 12-bit unsigned; no arithmetic SHALL be performed on addr or data.

Reset
REQ-028 While rst=1, the block SHALL hold state=ARB, rr_ptr=0, owner=0, vga_we=0, vga_addr=0, vga_data=0, addr_err=0, wr_count=0, busy=0, and ack=0.
REQ-029 A reset asserted mid-burst SHALL release the lock and drop the pending registered write, so vga_we=0 in the cycle after rst.

Verification
REQ-030 Bench: req=4'b1111, no locks, for 8 cycles -> ack sequence 0,1,2,3,0,1,2,3; vga_we high cycles 2-9; wr_count=8.
REQ-031 Bench: req[2] with lock for 3 writes (addresses 100,101,102), req[0] also high -> ack[0] stays 0 until the third write (lock=0); then ack[0] is granted the next cycle; busy is high during the burst.
REQ-032 Bench: req[1] with addr 12'd2400 -> ack[1]=1; next cycle vga_we=0, addr_err=1; wr_count unchanged.
REQ-033 Bench: owner 3 locked and drops req[3] -> busy falls next cycle; req[0] granted (rr_ptr wraps to 0).
REQ-034 Bench: rst asserted in the cycle after ack -> vga_we=0; all outputs at reset values.
REQ-035 Bench: preload wr_count=16'hFFFE via 2 extra legal writes -> wr_count stops at 16'hFFFF.
